micro_core: RTL and testbench
=============================

MICRO_CORE -- requirements
Module: micro_core

Interface
REQ-001 SHALL have parameter DATA_W, default 8, accumulator/RAM data width (4..32).
REQ-002 SHALL have parameter ROM_ADDR_W, default 8, program-counter width (must be <= DATA_W).
REQ-003 SHALL have parameter RAM_ADDR_W, default 8, data-memory address width (must be <= DATA_W).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port arst  input  1  reset, active-high, synchronous (sampled on clk rising edge only).
REQ-006 SHALL have port run  input  1  execution enable; 0 stalls the core in FETCH.
REQ-007 SHALL have port rom_addr  output  ROM_ADDR_W  instruction address, equal to PC.
REQ-008 SHALL have port rom_data  input  4+DATA_W  instruction word {opcode[3:0], operand[DATA_W-1:0]}, valid one cycle after rom_addr (synchronous ROM).
REQ-009 SHALL have port ram_addr  output  RAM_ADDR_W  data address, equal to operand[RAM_ADDR_W-1:0] of current instruction.
REQ-010 SHALL have port ram_wr_en  output  1  write strobe.
REQ-011 SHALL have port ram_data_rd  input  DATA_W  read data, valid in the cycle ram_ready=1 during MEM_RD.
REQ-012 SHALL have port ram_data_wr  output  DATA_W  write data, equal to ACC.
REQ-013 SHALL have port ram_ready  input  1  memory wait-state handshake; access completes in a cycle with ram_ready=1.
REQ-014 SHALL have ports acc_o (DATA_W), flags_o (4: {Z,N,C,V}), halted (1), all outputs, driven from registers.

Function
REQ-015 SHALL implement FSM states FETCH, DECODE, MEM_RD, EXEC, HALT.
REQ-016 FETCH: rom_addr=PC; if run=1 go DECODE, else remain in FETCH with no state change.
REQ-017 DECODE: IR<=rom_data, PC<=PC+1 (wraps modulo 2^ROM_ADDR_W); opcodes 2,4,5,6,7,8 go MEM_RD, all others go EXEC.
REQ-018 MEM_RD: hold ram_addr; stay until ram_ready=1, then MBR<=ram_data_rd and go EXEC.
REQ-019 EXEC: perform opcode, return to FETCH; for ST hold ram_wr_en=1 and stay in EXEC until ram_ready=1, then deassert ram_wr_en and go FETCH.
REQ-020 Opcodes: 0 NOP, 1 LDI (ACC=operand), 2 LD (ACC=MBR), 3 ST (mem=ACC), 4 ADD, 5 SUB, 6 AND, 7 OR, 8 XOR (ACC op MBR), 9 ADDI (ACC+operand), A JMP, B JZ, C JC, D SHL, E SHR, F HLT.
REQ-021 Latency: non-memory instruction 3 cycles; LD/ALU-memory 4 cycles + wait cycles; ST 3 cycles + wait cycles.
REQ-022 Arithmetic: ADD/ADDI C = carry-out of DATA_W-bit sum; SUB C = borrow (1 when ACC < MBR unsigned); V = two's-complement overflow; results truncated to DATA_W.
REQ-023 Flags: Z=(result==0), N=result[DATA_W-1]; ADD/SUB/ADDI update Z,N,C,V; AND/OR/XOR update Z,N and clear C,V; SHL/SHR update Z,N, C=shifted-out bit, V=0; LD/LDI update Z,N only; others leave flags unchanged.
REQ-024 Jumps: JMP, and JZ when Z=1, JC when C=1, SHALL set PC<=operand[ROM_ADDR_W-1:0] in EXEC, overriding the DECODE increment; not-taken leaves PC+1.
REQ-025 HLT: enter HALT, set halted=1; remain in HALT ignoring run and ram_ready until reset.
REQ-026 run=0 SHALL only take effect in FETCH; an instruction already in DECODE/MEM_RD/EXEC completes.
REQ-027 ram_wr_en SHALL be 1 only in EXEC of ST; never asserted in any other state.

Reset
REQ-028 arst=1 at a clock edge SHALL force state=FETCH, PC=0, IR=0, ACC=0, MBR=0, flags=0, ram_wr_en=0, halted=0, in any state including mid-wait.
REQ-029 Reset during ST wait SHALL deassert ram_wr_en in the cycle after the reset edge; no write completes.
REQ-030 arst SHALL have priority over run, ram_ready and all FSM transitions.

Verification
REQ-031 Program LDI 0x7F; ADDI 0x01; HLT, ram_ready=1 -> acc_o=0x80, flags Z=0,N=1,C=0,V=1, halted=1 after 9 cycles.
REQ-032 LDI 0x05; ST 0x10; LD 0x10 with ram_ready low 3 cycles per access -> ram_wr_en high 4 cycles, write addr 0x10 data 0x05, acc_o=0x05.
REQ-033 LDI 0x00; JZ 0x08 -> PC=0x08 at next FETCH; LDI 0x01; JZ 0x08 -> PC=0x04 (not taken).
REQ-034 LDI 0x03; SUB mem[0]=0x05 -> acc_o=0xFE, C=1, N=1, Z=0.
REQ-035 run=0 mid-LD -> LD completes, core holds in FETCH with PC unchanged until run=1.
REQ-036 arst pulsed during ST wait and in HALT -> all outputs at reset values next cycle, execution restarts at PC=0.

Source files
------------

// File: rtl/micro_core.sv
// +--------------------------------------------------------------------------+
// | Module      : micro_core                                                 |
// | Description : Accumulator micro-controller core. Fetches 4-bit opcode +  |
// |               DATA_W-bit operand words from a synchronous ROM, executes  |
// |               load/store/ALU/jump instructions against an external data  |
// |               memory with a ready handshake, and stops on HLT.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk          in   rising-edge clock                                    |
// |   arst         in   active-high reset, sampled on clk                     |
// |   run          in   execution enable, only looked at in FETCH            |
// |   rom_addr     out  instruction address (= PC)                           |
// |   rom_data     in   {opcode[3:0], operand}, one cycle after rom_addr     |
// |   ram_addr     out  data address (= operand low bits of IR)              |
// |   ram_wr_en    out  write strobe, high only during EXEC of ST            |
// |   ram_data_rd  in   read data, taken when ram_ready=1 in MEM_RD          |
// |   ram_data_wr  out  write data (= ACC)                                   |
// |   ram_ready    in   access completes in a cycle with ram_ready=1         |
// |   acc_o        out  accumulator                                          |
// |   flags_o      out  {Z, N, C, V}                                         |
// |   halted       out  high once HLT has executed                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module micro_core #(
  parameter int DATA_W     = 8,
  parameter int ROM_ADDR_W = 8,
  parameter int RAM_ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  run,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  input  logic [DATA_W+3:0]     rom_data,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic                  ram_wr_en,
  input  logic [DATA_W-1:0]     ram_data_rd,
  output logic [DATA_W-1:0]     ram_data_wr,
  input  logic                  ram_ready,
  output logic [DATA_W-1:0]     acc_o,
  output logic [3:0]            flags_o,
  output logic                  halted
);

  localparam int MSB = DATA_W - 1;

  localparam logic [3:0] c_OP_NOP  = 4'h0;
  localparam logic [3:0] c_OP_LDI  = 4'h1;
  localparam logic [3:0] c_OP_LD   = 4'h2;
  localparam logic [3:0] c_OP_ST   = 4'h3;
  localparam logic [3:0] c_OP_ADD  = 4'h4;
  localparam logic [3:0] c_OP_SUB  = 4'h5;
  localparam logic [3:0] c_OP_AND  = 4'h6;
  localparam logic [3:0] c_OP_OR   = 4'h7;
  localparam logic [3:0] c_OP_XOR  = 4'h8;
  localparam logic [3:0] c_OP_ADDI = 4'h9;
  localparam logic [3:0] c_OP_JMP  = 4'hA;
  localparam logic [3:0] c_OP_JZ   = 4'hB;
  localparam logic [3:0] c_OP_JC   = 4'hC;
  localparam logic [3:0] c_OP_SHL  = 4'hD;
  localparam logic [3:0] c_OP_SHR  = 4'hE;
  localparam logic [3:0] c_OP_HLT  = 4'hF;

  localparam logic [ROM_ADDR_W-1:0] c_PC_ONE = ROM_ADDR_W'(1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_MEM_RD = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  // Architectural and control registers
  state_t                state_q;
  logic [ROM_ADDR_W-1:0] pc_q;
  logic [DATA_W+3:0]     ir_q;
  logic [DATA_W-1:0]     acc_q;
  logic [DATA_W-1:0]     mbr_q;
  logic [3:0]            flags_q;     // {Z, N, C, V}
  logic                  ram_wr_en_q;
  logic                  halted_q;

  // Instruction fields
  logic [3:0]        opc;
  logic [DATA_W-1:0] opnd;
  logic [3:0]        dec_opc;
  logic              dec_mem_rd;

  assign opc     = ir_q[DATA_W+3:DATA_W];
  assign opnd    = ir_q[DATA_W-1:0];
  // In DECODE the instruction is still on the ROM bus, not yet in IR
  assign dec_opc = rom_data[DATA_W+3:DATA_W];

  always_comb begin
    dec_mem_rd = 1'b0;
    case (dec_opc)
      c_OP_LD, c_OP_ADD, c_OP_SUB,
      c_OP_AND, c_OP_OR, c_OP_XOR: dec_mem_rd = 1'b1;
      default:                     dec_mem_rd = 1'b0;
    endcase
  end

  // ALU / next-state values for EXEC
  logic [DATA_W:0]   sum_w;
  logic [DATA_W-1:0] res_w;
  logic [DATA_W-1:0] acc_d;
  logic [3:0]        flags_d;
  logic              c_w;
  logic              v_w;
  logic              upd_zn;
  logic              upd_cv;
  logic              take_jump;

  always_comb begin
    sum_w     = '0;
    res_w     = acc_q;
    c_w       = flags_q[1];
    v_w       = flags_q[0];
    upd_zn    = 1'b0;
    upd_cv    = 1'b0;
    take_jump = 1'b0;

    case (opc)
      c_OP_LDI: begin
        res_w  = opnd;
        upd_zn = 1'b1;
      end
      c_OP_LD: begin
        res_w  = mbr_q;
        upd_zn = 1'b1;
      end
      c_OP_ADD: begin
        sum_w  = {1'b0, acc_q} + {1'b0, mbr_q};
        res_w  = sum_w[DATA_W-1:0];
        c_w    = sum_w[DATA_W];
        // Overflow: operands share a sign that the result does not
        v_w    = (acc_q[MSB] == mbr_q[MSB]) && (res_w[MSB] != acc_q[MSB]);
        upd_zn = 1'b1;
        upd_cv = 1'b1;
      end
      c_OP_ADDI: begin
        sum_w  = {1'b0, acc_q} + {1'b0, opnd};
        res_w  = sum_w[DATA_W-1:0];
        c_w    = sum_w[DATA_W];
        v_w    = (acc_q[MSB] == opnd[MSB]) && (res_w[MSB] != acc_q[MSB]);
        upd_zn = 1'b1;
        upd_cv = 1'b1;
      end
      c_OP_SUB: begin
        // The extra top bit of a widened subtraction is the borrow
        sum_w  = {1'b0, acc_q} - {1'b0, mbr_q};
        res_w  = sum_w[DATA_W-1:0];
        c_w    = sum_w[DATA_W];
        // Overflow: operands differ in sign and result sign flips from ACC
        v_w    = (acc_q[MSB] != mbr_q[MSB]) && (res_w[MSB] != acc_q[MSB]);
        upd_zn = 1'b1;
        upd_cv = 1'b1;
      end
      c_OP_AND, c_OP_OR, c_OP_XOR: begin
        if (opc == c_OP_AND)     res_w = acc_q & mbr_q;
        else if (opc == c_OP_OR) res_w = acc_q | mbr_q;
        else                     res_w = acc_q ^ mbr_q;
        c_w    = 1'b0;
        v_w    = 1'b0;
        upd_zn = 1'b1;
        upd_cv = 1'b1;
      end
      c_OP_SHL: begin
        res_w  = {acc_q[MSB-1:0], 1'b0};
        c_w    = acc_q[MSB];
        v_w    = 1'b0;
        upd_zn = 1'b1;
        upd_cv = 1'b1;
      end
      c_OP_SHR: begin
        res_w  = {1'b0, acc_q[MSB:1]};
        c_w    = acc_q[0];
        v_w    = 1'b0;
        upd_zn = 1'b1;
        upd_cv = 1'b1;
      end
      c_OP_JMP: take_jump = 1'b1;
      c_OP_JZ:  take_jump = flags_q[3];
      c_OP_JC:  take_jump = flags_q[1];
      default: begin
        // NOP, ST, HLT: accumulator and flags untouched
      end
    endcase

    acc_d   = res_w;
    flags_d = flags_q;
    if (upd_zn) flags_d[3:2] = {(res_w == '0), res_w[MSB]};
    if (upd_cv) flags_d[1:0] = {c_w, v_w};
  end

  // Control FSM and all architectural state
  always_ff @(posedge clk) begin
    if (arst) begin
      state_q     <= S_FETCH;
      pc_q        <= '0;
      ir_q        <= '0;
      acc_q       <= '0;
      mbr_q       <= '0;
      flags_q     <= '0;
      ram_wr_en_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (run) state_q <= S_DECODE;
        end

        S_DECODE: begin
          ir_q <= rom_data;
          pc_q <= pc_q + c_PC_ONE;
          // Strobe is raised here so it is already high on the first EXEC cycle
          ram_wr_en_q <= (dec_opc == c_OP_ST);
          state_q     <= dec_mem_rd ? S_MEM_RD : S_EXEC;
        end

        S_MEM_RD: begin
          if (ram_ready) begin
            mbr_q   <= ram_data_rd;
            state_q <= S_EXEC;
          end
        end

        S_EXEC: begin
          if (opc == c_OP_ST) begin
            if (ram_ready) begin
              ram_wr_en_q <= 1'b0;
              state_q     <= S_FETCH;
            end
          end else if (opc == c_OP_HLT) begin
            halted_q <= 1'b1;
            state_q  <= S_HALT;
          end else begin
            acc_q   <= acc_d;
            flags_q <= flags_d;
            if (take_jump) pc_q <= opnd[ROM_ADDR_W-1:0];
            state_q <= S_FETCH;
          end
        end

        S_HALT: begin
          state_q <= S_HALT;
        end

        default: begin
          state_q <= S_FETCH;
        end
      endcase
    end
  end

  assign rom_addr    = pc_q;
  assign ram_addr    = ir_q[RAM_ADDR_W-1:0];
  assign ram_wr_en   = ram_wr_en_q;
  assign ram_data_wr = acc_q;
  assign acc_o       = acc_q;
  assign flags_o     = flags_q;
  assign halted      = halted_q;

endmodule

`default_nettype wire

// File: tb/tb_micro_core.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_micro_core                                              |
// | Description : Self-checking bench for micro_core: directed scenarios     |
// |               plus random programs compared against an instruction-level |
// |               reference model.                                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_micro_core;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic        clk = 1'b0;
  logic        arst;
  logic        run;
  logic        ram_ready;
  logic [7:0]  rom_addr;
  logic [11:0] rom_data;
  logic [7:0]  ram_addr;
  logic        ram_wr_en;
  logic [7:0]  ram_data_rd;
  logic [7:0]  ram_data_wr;
  logic [7:0]  acc_o;
  logic [3:0]  flags_o;
  logic        halted;

  logic [11:0] rom_mem [256];
  logic [7:0]  ram_mem [256];
  int          mram    [256];
  wr_t         seen_wr [$];
  wr_t         exp_wr  [$];

  int n_checks = 0;
  int n_errors = 0;

  micro_core #(
    .DATA_W     (8),
    .ROM_ADDR_W (8),
    .RAM_ADDR_W (8)
  ) dut (
    .clk         (clk),
    .arst        (arst),
    .run         (run),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .ram_addr    (ram_addr),
    .ram_wr_en   (ram_wr_en),
    .ram_data_rd (ram_data_rd),
    .ram_data_wr (ram_data_wr),
    .ram_ready   (ram_ready),
    .acc_o       (acc_o),
    .flags_o     (flags_o),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  // Synchronous ROM
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  assign ram_data_rd = ram_mem[ram_addr];

  // One clock: commit a write that the coming edge completes, then move to
  // the next falling edge where outputs are sampled and inputs changed.
  task automatic cycle();
    wr_t w;
    if (ram_wr_en === 1'b1 && ram_ready === 1'b1 && arst === 1'b0) begin
      w.addr = int'(ram_addr);
      w.data = int'(ram_data_wr);
      ram_mem[ram_addr] = ram_data_wr;
      seen_wr.push_back(w);
    end
    @(negedge clk);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      rom_mem[i] = 12'hF00;
      ram_mem[i] = 8'h00;
    end
  endtask

  task automatic do_reset();
    arst = 1'b1;
    cycle();
    arst = 1'b0;
    seen_wr.delete();
  endtask

  function automatic int sgn(int a);
    return (a >= 128) ? a - 256 : a;
  endfunction

  // Instruction-level model: executes the program in rom_mem against a copy
  // of ram_mem, producing final ACC/flags, write list and ideal cycle count.
  task automatic model_program(output int e_acc, output logic [3:0] e_flags,
                               output int e_cycles, output bit done);
    int pc, acc, z, n, c, v, op, x, m, b, s;
    wr_t w;
    pc = 0; acc = 0; z = 0; n = 0; c = 0; v = 0; e_cycles = 0; done = 1'b0;
    exp_wr.delete();
    for (int i = 0; i < 256; i++) mram[i] = int'(ram_mem[i]);
    for (int step = 0; step < 2000 && !done; step++) begin
      op = int'(rom_mem[pc][11:8]);
      x  = int'(rom_mem[pc][7:0]);
      pc = (pc + 1) % 256;
      m  = 0;
      if (op == 2 || (op >= 4 && op <= 8)) begin
        m = mram[x];
        e_cycles += 4;
      end else begin
        e_cycles += 3;
      end
      case (op)
        1: acc = x;
        2: acc = m;
        3: begin
          w.addr = x; w.data = acc;
          exp_wr.push_back(w);
          mram[x] = acc;
        end
        4, 9: begin
          b = (op == 4) ? m : x;
          s = sgn(acc) + sgn(b);
          c = (acc + b > 255) ? 1 : 0;
          v = (s > 127 || s < -128) ? 1 : 0;
          acc = (acc + b) % 256;
        end
        5: begin
          s = sgn(acc) - sgn(m);
          c = (acc < m) ? 1 : 0;
          v = (s > 127 || s < -128) ? 1 : 0;
          acc = (acc - m + 256) % 256;
        end
        6: begin acc = acc & m; c = 0; v = 0; end
        7: begin acc = acc | m; c = 0; v = 0; end
        8: begin acc = acc ^ m; c = 0; v = 0; end
        10: pc = x;
        11: if (z == 1) pc = x;
        12: if (c == 1) pc = x;
        13: begin c = acc / 128; acc = (acc * 2) % 256; v = 0; end
        14: begin c = acc % 2; acc = acc / 2; v = 0; end
        15: done = 1'b1;
        default: ;
      endcase
      if (op == 1 || op == 2 || (op >= 4 && op <= 9) || op == 13 || op == 14) begin
        z = (acc == 0) ? 1 : 0;
        n = (acc >= 128) ? 1 : 0;
      end
    end
    e_acc   = acc;
    e_flags = {z[0], n[0], c[0], v[0]};
  endtask

  task automatic test_reset();
    run = 1'b0; ram_ready = 1'b0;
    clear_mem();
    do_reset();
    repeat (2) do_reset();
    n_checks++; if (rom_addr !== 8'h00) begin n_errors++; $display("FAIL reset_rom_addr got %h want 00", rom_addr); end
    n_checks++; if (ram_wr_en !== 1'b0) begin n_errors++; $display("FAIL reset_wr_en got %b want 0", ram_wr_en); end
    n_checks++; if (acc_o !== 8'h00) begin n_errors++; $display("FAIL reset_acc got %h want 00", acc_o); end
    n_checks++; if (flags_o !== 4'h0) begin n_errors++; $display("FAIL reset_flags got %b want 0000", flags_o); end
    n_checks++; if (halted !== 1'b0) begin n_errors++; $display("FAIL reset_halted got %b want 0", halted); end
  endtask

  task automatic test_overflow();
    clear_mem();
    rom_mem[0] = 12'h17F; rom_mem[1] = 12'h901; rom_mem[2] = 12'hF00;
    run = 1'b1; ram_ready = 1'b1;
    do_reset();
    repeat (8) cycle();
    n_checks++; if (halted !== 1'b0) begin n_errors++; $display("FAIL ovf_halt_early got %b want 0 at cycle 8", halted); end
    cycle();
    n_checks++; if (halted !== 1'b1) begin n_errors++; $display("FAIL ovf_halted got %b want 1 at cycle 9", halted); end
    n_checks++; if (acc_o !== 8'h80) begin n_errors++; $display("FAIL ovf_acc got %h want 80", acc_o); end
    n_checks++; if (flags_o !== 4'b0101) begin n_errors++; $display("FAIL ovf_flags got %b want 0101", flags_o); end
    // HALT ignores run and ram_ready
    run = 1'b0; ram_ready = 1'b0;
    repeat (3) cycle();
    n_checks++; if (halted !== 1'b1 || rom_addr !== 8'h03) begin n_errors++; $display("FAIL halt_hold got halted=%b pc=%h want 1/03", halted, rom_addr); end
  endtask

  task automatic test_store_load_wait();
    int wr_cycles;
    clear_mem();
    rom_mem[0] = 12'h105; rom_mem[1] = 12'h310; rom_mem[2] = 12'h210;
    ram_mem[8'h10] = 8'hAA;
    run = 1'b1; ram_ready = 1'b1;
    do_reset();
    wr_cycles = 0;
    // ST completes on edge 9, LD read completes on edge 15; ready low otherwise
    for (int k = 1; k <= 19; k++) begin
      ram_ready = (k == 9 || k == 15);
      if (ram_wr_en === 1'b1) wr_cycles++;
      cycle();
    end
    n_checks++; if (wr_cycles != 4) begin n_errors++; $display("FAIL st_wr_cycles got %0d want 4", wr_cycles); end
    n_checks++;
    if (seen_wr.size() != 1 || seen_wr[0].addr != 'h10 || seen_wr[0].data != 'h05) begin
      n_errors++;
      $display("FAIL st_write got n=%0d addr=%0h data=%0h want 1 write 10/05", seen_wr.size(),
               (seen_wr.size() > 0) ? seen_wr[0].addr : -1, (seen_wr.size() > 0) ? seen_wr[0].data : -1);
    end
    n_checks++; if (acc_o !== 8'h05 || halted !== 1'b1) begin n_errors++; $display("FAIL ld_acc got acc=%h halted=%b want 05/1", acc_o, halted); end
    n_checks++; if (ram_wr_en !== 1'b0) begin n_errors++; $display("FAIL st_wr_release got %b want 0", ram_wr_en); end
  endtask

  task automatic test_jumps();
    clear_mem();
    rom_mem[0] = 12'h100; rom_mem[1] = 12'hB08;
    run = 1'b1; ram_ready = 1'b1;
    do_reset();
    repeat (6) cycle();
    n_checks++; if (rom_addr !== 8'h08) begin n_errors++; $display("FAIL jz_taken got pc=%h want 08", rom_addr); end

    clear_mem();
    rom_mem[0] = 12'h000; rom_mem[1] = 12'h000; rom_mem[2] = 12'h101; rom_mem[3] = 12'hB08;
    do_reset();
    repeat (12) cycle();
    n_checks++; if (rom_addr !== 8'h04) begin n_errors++; $display("FAIL jz_not_taken got pc=%h want 04", rom_addr); end

    clear_mem();
    rom_mem[0] = 12'h1FF; rom_mem[1] = 12'h901; rom_mem[2] = 12'hC20;
    do_reset();
    repeat (9) cycle();
    n_checks++; if (rom_addr !== 8'h20 || flags_o !== 4'b1010) begin n_errors++; $display("FAIL jc_taken got pc=%h flags=%b want 20/1010", rom_addr, flags_o); end
  endtask

  task automatic test_sub();
    int cyc;
    clear_mem();
    ram_mem[0] = 8'h05;
    rom_mem[0] = 12'h103; rom_mem[1] = 12'h500;
    run = 1'b1; ram_ready = 1'b1;
    do_reset();
    cyc = 0;
    while (halted !== 1'b1 && cyc < 50) begin cycle(); cyc++; end
    n_checks++; if (cyc != 10) begin n_errors++; $display("FAIL sub_latency got %0d want 10", cyc); end
    n_checks++; if (acc_o !== 8'hFE) begin n_errors++; $display("FAIL sub_acc got %h want fe", acc_o); end
    n_checks++; if (flags_o !== 4'b0110) begin n_errors++; $display("FAIL sub_flags got %b want 0110", flags_o); end
  endtask

  task automatic test_run_stall();
    clear_mem();
    ram_mem[8'h20] = 8'h33;
    rom_mem[0] = 12'h220;
    run = 1'b1; ram_ready = 1'b1;
    do_reset();
    cycle();            // now in DECODE of LD
    run = 1'b0;
    repeat (4) cycle();
    n_checks++; if (acc_o !== 8'h33) begin n_errors++; $display("FAIL stall_ld_done got %h want 33", acc_o); end
    repeat (8) cycle();
    n_checks++; if (rom_addr !== 8'h01 || halted !== 1'b0) begin n_errors++; $display("FAIL stall_hold got pc=%h halted=%b want 01/0", rom_addr, halted); end
    run = 1'b1;
    repeat (3) cycle();
    n_checks++; if (halted !== 1'b1) begin n_errors++; $display("FAIL stall_resume got halted=%b want 1", halted); end
  endtask

  task automatic test_reset_midwait();
    int cyc;
    clear_mem();
    ram_mem[8'h10] = 8'hAA;
    rom_mem[0] = 12'h105; rom_mem[1] = 12'h310;
    run = 1'b1; ram_ready = 1'b0;
    do_reset();
    repeat (7) cycle();
    n_checks++; if (ram_wr_en !== 1'b1) begin n_errors++; $display("FAIL midwait_wr_en got %b want 1", ram_wr_en); end
    arst = 1'b1;
    cycle();
    arst = 1'b0;
    n_checks++;
    if (ram_wr_en !== 1'b0 || acc_o !== 8'h00 || flags_o !== 4'h0 || rom_addr !== 8'h00 || halted !== 1'b0) begin
      n_errors++;
      $display("FAIL midwait_reset got wr=%b acc=%h flags=%b pc=%h halted=%b want 0/00/0000/00/0",
               ram_wr_en, acc_o, flags_o, rom_addr, halted);
    end
    n_checks++; if (ram_mem[8'h10] !== 8'hAA) begin n_errors++; $display("FAIL midwait_no_write got %h want aa", ram_mem[8'h10]); end
    ram_ready = 1'b1;
    cyc = 0;
    while (halted !== 1'b1 && cyc < 40) begin cycle(); cyc++; end
    n_checks++; if (halted !== 1'b1 || ram_mem[8'h10] !== 8'h05) begin n_errors++; $display("FAIL restart got halted=%b mem=%h want 1/05", halted, ram_mem[8'h10]); end
    arst = 1'b1;
    cycle();
    arst = 1'b0;
    n_checks++;
    if (halted !== 1'b0 || acc_o !== 8'h00 || rom_addr !== 8'h00 || ram_wr_en !== 1'b0) begin
      n_errors++;
      $display("FAIL halt_reset got halted=%b acc=%h pc=%h wr=%b want 0/00/00/0", halted, acc_o, rom_addr, ram_wr_en);
    end
    repeat (3) cycle();
    n_checks++; if (acc_o !== 8'h05 || rom_addr !== 8'h01) begin n_errors++; $display("FAIL halt_restart got acc=%h pc=%h want 05/01", acc_o, rom_addr); end
  endtask

  task automatic test_random();
    int op, x, len, cyc, e_acc, e_cycles, diffs;
    logic [3:0] e_flags;
    bit done, rnd;
    for (int t = 0; t < 24; t++) begin
      rnd = (t % 2 == 1);
      clear_mem();
      for (int i = 0; i < 16; i++) ram_mem[i] = 8'($urandom);
      len = $urandom_range(8, 30);
      for (int i = 0; i < len; i++) begin
        op = $urandom_range(0, 14);
        if (op == 2 || (op >= 3 && op <= 8)) x = $urandom_range(0, 15);
        else if (op >= 10 && op <= 12)       x = $urandom_range(i + 1, 40);
        else                                  x = $urandom_range(0, 255);
        rom_mem[i] = {4'(op), 8'(x)};
      end
      model_program(e_acc, e_flags, e_cycles, done);
      run = 1'b1; ram_ready = 1'b1;
      do_reset();
      cyc = 0;
      while (halted !== 1'b1 && cyc < 3000) begin
        if (rnd) begin
          ram_ready = ($urandom_range(0, 2) != 0);
          run       = ($urandom_range(0, 3) != 0);
        end
        cycle();
        cyc++;
      end
      n_checks++; if (halted !== 1'b1 || !done) begin n_errors++; $display("FAIL rand%0d_timeout got halted=%b after %0d cycles want 1", t, halted, cyc); end
      n_checks++; if (int'(acc_o) != e_acc) begin n_errors++; $display("FAIL rand%0d_acc got %h want %0h", t, acc_o, e_acc); end
      n_checks++; if (flags_o !== e_flags) begin n_errors++; $display("FAIL rand%0d_flags got %b want %b", t, flags_o, e_flags); end
      if (!rnd) begin
        n_checks++; if (cyc != e_cycles) begin n_errors++; $display("FAIL rand%0d_latency got %0d want %0d", t, cyc, e_cycles); end
      end
      n_checks++;
      if (seen_wr.size() != exp_wr.size()) begin
        n_errors++; $display("FAIL rand%0d_wr_count got %0d want %0d", t, seen_wr.size(), exp_wr.size());
      end else begin
        diffs = 0;
        for (int i = 0; i < exp_wr.size(); i++)
          if (seen_wr[i].addr != exp_wr[i].addr || seen_wr[i].data != exp_wr[i].data) diffs++;
        if (diffs != 0) begin n_errors++; $display("FAIL rand%0d_wr_data got %0d wrong writes want 0", t, diffs); end
      end
      diffs = 0;
      for (int i = 0; i < 16; i++) if (int'(ram_mem[i]) != mram[i]) diffs++;
      n_checks++; if (diffs != 0) begin n_errors++; $display("FAIL rand%0d_ram got %0d differing words want 0", t, diffs); end
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired, simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    arst = 1'b1; run = 1'b0; ram_ready = 1'b0;
    test_reset();
    test_overflow();
    test_store_load_wait();
    test_jumps();
    test_sub();
    test_run_stall();
    test_reset_midwait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
